// File: rtl/reg_file_mp.sv
// Multi-ported register file with a per-register busy scoreboard for the pipelined MIPS core.
// Reads are combinational with optional same-cycle write bypass; register 0 may be hardwired to zero.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  input  logic                         flush,
  output logic                         wr_conflict
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam bit ZERO_EN = (ZERO_REG != 0);
  localparam bit BYP_EN  = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  wr_conflict_q;
  logic                  wr_conflict_d;
  logic [NUM_WR-1:0]     wr_act;
  logic                  rsv_act;

  // A write to register 0 is dropped entirely when it is hardwired, so it never counts anywhere.
  always_comb begin
    wr_act = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_act[k] = wr_en[k] &
                  ~(ZERO_EN & (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}}));
    end
    rsv_act = rsv_en & ~(ZERO_EN & (rsv_addr == {ADDR_WIDTH{1'b0}}));
  end

  // Next register contents; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NUM_WR; k++) begin
      regs_d[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] = wr_act[k] ?
          wr_data[k*DATA_WIDTH +: DATA_WIDTH] : regs_d[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Scoreboard: flush beats reserve, and a reserve supersedes a same-cycle completing write.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      busy_d[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] =
          busy_d[wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] & ~wr_act[k];
    end
    busy_d[rsv_addr] = busy_d[rsv_addr] | rsv_act;
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Collision detect across every pair of live write ports.
  always_comb begin
    wr_conflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        wr_conflict_d = wr_conflict_d | (wr_act[i] & wr_act[j] &
            (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]));
      end
    end
  end

  // Read ports; a bypass hit also hides the busy bit since the data is already here.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_busy[r] = busy_q[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      for (int k = 0; k < NUM_WR; k++) begin
        if (BYP_EN && wr_act[k] &&
            (wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rd_data[r*DATA_WIDTH +: DATA_WIDTH] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
          rd_busy[r] = 1'b0;
        end else begin
          rd_busy[r] = rd_busy[r];
        end
      end
      if (ZERO_EN && (rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}})) begin
        rd_data[r*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        rd_busy[r] = 1'b0;
      end else begin
        rd_busy[r] = rd_busy[r];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypass/zero-reg build and a plain build driven in parallel,
// checked against a behavioural array model with directed steps followed by random traffic.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        conf_a, conf_b;

  reg_file_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .wr_conflict(conf_a)
  );

  reg_file_mp #(.BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .wr_conflict(conf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus fields; config 0 = bypass + zero reg, config 1 = neither.
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];

  logic [31:0] mem    [2][32];
  logic [31:0] busy_m [2];
  logic        conf_m [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int c, input logic [4:0] a);
    bit zr = (c == 0);
    if (zr && a == 5'd0) return 32'd0;
    if (c == 0) begin
      for (int k = 1; k >= 0; k--) begin
        if (we[k] && !(zr && wa[k] == 5'd0) && wa[k] == a) return wd[k];
      end
    end
    return mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [4:0] a);
    bit zr = (c == 0);
    if (zr && a == 5'd0) return 1'b0;
    if (c == 0) begin
      for (int k = 0; k < 2; k++) begin
        if (we[k] && !(zr && wa[k] == 5'd0) && wa[k] == a) return 1'b0;
      end
    end
    return busy_m[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 32; a++) mem[c][a] = 32'd0;
      busy_m[c] = 32'd0;
      conf_m[c] = 1'b0;
    end
  endtask

  task automatic model_next();
    for (int c = 0; c < 2; c++) begin
      bit zr = (c == 0);
      int cnt [32];
      for (int a = 0; a < 32; a++) cnt[a] = 0;
      for (int k = 0; k < 2; k++) begin
        if (we[k] && !(zr && wa[k] == 5'd0)) begin
          mem[c][wa[k]] = wd[k];
          cnt[wa[k]]++;
          busy_m[c][wa[k]] = 1'b0;
        end
      end
      if (flush) busy_m[c] = 32'd0;
      else if (rsv_en && !(zr && rsv_addr == 5'd0)) busy_m[c][rsv_addr] = 1'b1;
      conf_m[c] = 1'b0;
      for (int a = 0; a < 32; a++) if (cnt[a] >= 2) conf_m[c] = 1'b1;
    end
  endtask

  task automatic idle();
    we = 2'b00; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic settle();
    wr_en   = we;
    wr_addr = {wa[1], wa[0]};
    wr_data = {wd[1], wd[0]};
    rd_addr = {ra[1], ra[0]};
    #2;
  endtask

  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 2; r++) begin
        logic [31:0] od;
        logic ob;
        od = (c == 0) ? rd_data_a[r*32 +: 32] : rd_data_b[r*32 +: 32];
        ob = (c == 0) ? rd_busy_a[r] : rd_busy_b[r];
        chk($sformatf("rd_data cfg%0d port%0d addr%0d", c, r, ra[r]), od, exp_data(c, ra[r]));
        chk($sformatf("rd_busy cfg%0d port%0d addr%0d", c, r, ra[r]), {31'd0, ob},
            {31'd0, exp_busy(c, ra[r])});
      end
      chk($sformatf("wr_conflict cfg%0d", c), {31'd0, (c == 0) ? conf_a : conf_b},
          {31'd0, conf_m[c]});
    end
  endtask

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    check_all();
    advance();
  endtask

  // Reset asserted in the middle of a write cycle; the writes must be lost.
  task automatic reset_seq();
    we = 2'b11; wa[0] = 5'd3; wd[0] = 32'hCAFE_0003; wa[1] = 5'd7; wd[1] = 32'hCAFE_0007;
    rsv_en = 1'b1; rsv_addr = 5'd3; flush = 1'b0;
    settle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    idle();
    ra[0] = 5'd3; ra[1] = 5'd7;
    settle();
    check_all();
    chk("reset rd3", rd_data_a[31:0], 32'd0);
    chk("reset rd7 nb", rd_data_b[63:32], 32'd0);
    chk("reset busy", {30'd0, rd_busy_a}, 32'd0);
    chk("reset conflict", {31'd0, conf_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rsv_addr = 5'd0;
    for (int k = 0; k < 2; k++) begin wa[k] = 5'd0; wd[k] = 32'd0; ra[k] = 5'd0; end
    model_reset();
    settle();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    reset_seq();

    // Parallel write to distinct addresses.
    idle(); we = 2'b11; wa[0] = 5'd3; wd[0] = 32'hAAAA_0001; wa[1] = 5'd7; wd[1] = 32'h5555_0002;
    ra[0] = 5'd1; ra[1] = 5'd2;
    step();
    idle(); ra[0] = 5'd3; ra[1] = 5'd7;
    settle(); check_all();
    chk("par rd3", rd_data_a[31:0], 32'hAAAA_0001);
    chk("par rd7", rd_data_a[63:32], 32'h5555_0002);
    chk("par conflict", {31'd0, conf_a}, 32'd0);
    advance();

    // Collision: port 1 wins, conflict pulses for one cycle.
    idle(); we = 2'b11; wa[0] = 5'd4; wd[0] = 32'h11; wa[1] = 5'd4; wd[1] = 32'h22;
    step();
    idle(); ra[0] = 5'd4;
    settle(); check_all();
    chk("coll rd4", rd_data_a[31:0], 32'h22);
    chk("coll pulse", {31'd0, conf_a}, 32'd1);
    advance();
    settle(); check_all();
    chk("coll pulse end", {31'd0, conf_a}, 32'd0);
    advance();

    // Bypass vs. plain build.
    idle(); we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h0000_DEAD; ra[0] = 5'd9;
    settle(); check_all();
    chk("bypass rd9", rd_data_a[31:0], 32'h0000_DEAD);
    chk("nobypass rd9", rd_data_b[31:0], 32'd0);
    advance();

    // Scoreboard.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd5; ra[0] = 5'd5;
    settle(); check_all();
    chk("rsv same cycle", {31'd0, rd_busy_a[0]}, 32'd0);
    advance();
    idle(); settle(); check_all();
    chk("rsv busy", {31'd0, rd_busy_a[0]}, 32'd1);
    advance();
    idle(); we = 2'b01; wa[0] = 5'd5; wd[0] = 32'h55;
    settle(); check_all();
    chk("wr5 bypass busy", {31'd0, rd_busy_a[0]}, 32'd0);
    chk("wr5 plain busy", {31'd0, rd_busy_b[0]}, 32'd1);
    advance();
    idle(); settle(); check_all();
    chk("wr5 cleared", {31'd0, rd_busy_b[0]}, 32'd0);
    advance();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd5; we = 2'b10; wa[1] = 5'd5; wd[1] = 32'h56;
    step();
    idle(); rsv_en = 1'b1; rsv_addr = 5'd6; ra[1] = 5'd6;
    settle(); check_all();
    chk("rsv+wr stays busy", {31'd0, rd_busy_a[0]}, 32'd1);
    advance();
    idle(); flush = 1'b1;
    step();
    idle(); settle(); check_all();
    chk("flush busy", {30'd0, rd_busy_a}, 32'd0);
    advance();

    // Zero register.
    idle(); we = 2'b11; wa[0] = 5'd0; wd[0] = 32'h0000_FFFF; wa[1] = 5'd0; wd[1] = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd0; ra[0] = 5'd0;
    settle(); check_all();
    chk("zero bypass", rd_data_a[31:0], 32'd0);
    advance();
    idle(); settle(); check_all();
    chk("zero rd", rd_data_a[31:0], 32'd0);
    chk("zero busy", {31'd0, rd_busy_a[0]}, 32'd0);
    chk("zero conflict", {31'd0, conf_a}, 32'd0);
    chk("plain reg0 conflict", {31'd0, conf_b}, 32'd1);
    advance();

    // Random traffic over a narrow address window to provoke hazards and collisions.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_seq();
      we       = 2'($urandom_range(0, 3));
      wa[0]    = 5'($urandom_range(0, 7));
      wa[1]    = 5'($urandom_range(0, 7));
      wd[0]    = $urandom;
      wd[1]    = $urandom;
      ra[0]    = 5'($urandom_range(0, 7));
      ra[1]    = 5'($urandom_range(0, 7));
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
